// File: rtl/mpc_mux.sv
// -----------------------------------------------------------------------------
// mpc_mux -- next-PC selector and program counter register.
//
// Selects either the sequential next PC (pcp, PC+1) or the jump/branch target
// (pcj) under control of `choice`. The selection is presented combinationally
// on `out`. A registered copy, pc_q, is the program counter that feeds
// instruction fetch.
//
// Optional feature macro: MPC_JCNT_EN
//   When defined, this block adds an 8-bit saturating counter of taken jumps,
//   presented on `jcnt`. When undefined, the jcnt port and its logic are absent.
//
// Parameters
//   WIDTH    bit width of pcp, pcj, out and pc_q
//   RST_PC   value loaded into pc_q by reset
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous reset, active-low
//   pcp      in   WIDTH  sequential next PC (PC+1)
//   pcj      in   WIDTH  jump/branch target PC
//   choice   in   1      1 = select pcj, 0 = select pcp
//   ld       in   1      1 = capture `out` into pc_q on the next rising clk
//   out      out  WIDTH  combinational selected next PC
//   pc_q     out  WIDTH  registered program counter
//   taken_q  out  1      1 when the last load was a jump
//   jcnt     out  8      taken-jump counter (only with MPC_JCNT_EN)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mpc_mux #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] RST_PC = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pcp,
  input  logic [WIDTH-1:0] pcj,
  input  logic             choice,
  input  logic             ld,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] pc_q,
  output logic             taken_q
`ifdef MPC_JCNT_EN
  ,
  output logic [7:0]       jcnt
`endif
);

  logic [WIDTH-1:0] out_s;
  logic [WIDTH-1:0] pc_r;
  logic             taken_r;

  // Next-PC mux; stays live during reset since it has no clock dependence.
  always_comb begin
    out_s = pcp;
    if (choice) begin
      out_s = pcj;
    end else begin
      out_s = pcp;
    end
  end

  assign out = out_s;

  // Program counter and jump-taken flag; reset overrides any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= RST_PC;
      taken_r <= 1'b0;
    end else if (ld) begin
      pc_r    <= out_s;
      taken_r <= choice;
    end
  end

  assign pc_q    = pc_r;
  assign taken_q = taken_r;

`ifdef MPC_JCNT_EN
  logic [7:0] jcnt_r;

  // Taken-jump counter; saturates at 8'hFF rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jcnt_r <= 8'h00;
    end else if (ld && choice && (jcnt_r != 8'hFF)) begin
      jcnt_r <= jcnt_r + 8'h01;
    end
  end

  assign jcnt = jcnt_r;
`endif

endmodule

// File: tb/tb_mpc_mux.sv
`timescale 1ns/1ps

module tb_mpc_mux;

  typedef struct {
    string      name;
    logic [7:0] exp_out;
    logic [7:0] exp_pc;
    logic       exp_taken;
    logic [7:0] exp_jcnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] pcp;
  logic [7:0] pcj;
  logic       choice;
  logic       ld;
  logic [7:0] out;
  logic [7:0] pc_q;
  logic       taken_q;
`ifdef MPC_JCNT_EN
  logic [7:0] jcnt;
`endif

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  mpc_mux #(.WIDTH(8), .RST_PC(8'h00)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pcp     (pcp),
    .pcj     (pcj),
    .choice  (choice),
    .ld      (ld),
    .out     (out),
    .pc_q    (pc_q),
    .taken_q (taken_q)
`ifdef MPC_JCNT_EN
    ,
    .jcnt    (jcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  function automatic void check8(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, got, exp);
  endfunction

  // Monitor: outputs are settled mid-cycle, so compare every queued expectation there.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check8({e.name, ".out"},     out,            e.exp_out);
        check8({e.name, ".pc_q"},    pc_q,           e.exp_pc);
        check8({e.name, ".taken_q"}, {7'd0, taken_q}, {7'd0, e.exp_taken});
`ifdef MPC_JCNT_EN
        check8({e.name, ".jcnt"},    jcnt,           e.exp_jcnt);
`endif
      end
    end
  end

  // Drive one cycle of inputs just after a rising edge and queue the state
  // expected before the next rising edge.
  task automatic cyc(input string nm, input logic r, input logic [7:0] p, input logic [7:0] j,
                     input logic c, input logic l, input logic [7:0] eo, input logic [7:0] ep,
                     input logic et, input logic [7:0] ej);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n  = r;
    pcp    = p;
    pcj    = j;
    choice = c;
    ld     = l;
    e.name = nm; e.exp_out = eo; e.exp_pc = ep; e.exp_taken = et; e.exp_jcnt = ej;
    q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; pcp = 8'd2; pcj = 8'd124; choice = 1'b1; ld = 1'b1;
    //   name            rst   pcp    pcj    ch    ld    out    pc     tk    jcnt
    cyc("rst_jump",     1'b0, 8'd2,  8'd124, 1'b1, 1'b1, 8'd124, 8'h00, 1'b0, 8'd0);
    cyc("rst_seq",      1'b0, 8'd14, 8'd124, 1'b0, 1'b1, 8'd14,  8'h00, 1'b0, 8'd0);
    cyc("release",      1'b1, 8'd14, 8'd124, 1'b0, 1'b1, 8'd14,  8'h00, 1'b0, 8'd0);
    cyc("load_seq",     1'b1, 8'd14, 8'd124, 1'b1, 1'b1, 8'd124, 8'd14, 1'b0, 8'd0);
    cyc("load_jump",    1'b1, 8'hFF, 8'd124, 1'b0, 1'b0, 8'hFF,  8'd124, 1'b1, 8'd1);
    cyc("hold_tog1",    1'b1, 8'hFF, 8'd124, 1'b1, 1'b0, 8'd124, 8'd124, 1'b1, 8'd1);
    cyc("hold_tog2",    1'b1, 8'hFF, 8'd124, 1'b0, 1'b0, 8'hFF,  8'd124, 1'b1, 8'd1);
    cyc("wrap_ld",      1'b1, 8'hFF, 8'd124, 1'b0, 1'b1, 8'hFF,  8'd124, 1'b1, 8'd1);
    cyc("wrap_res",     1'b1, 8'h33, 8'h80,  1'b1, 1'b0, 8'h80,  8'hFF,  1'b0, 8'd1);
    cyc("jump_ld",      1'b1, 8'h33, 8'h80,  1'b1, 1'b1, 8'h80,  8'hFF,  1'b0, 8'd1);
    cyc("jump_res",     1'b1, 8'h33, 8'h80,  1'b0, 1'b0, 8'h33,  8'h80,  1'b1, 8'd2);
    cyc("midrun_rst",   1'b0, 8'h33, 8'h55,  1'b1, 1'b1, 8'h55,  8'h00,  1'b0, 8'd0);
    cyc("post_rst",     1'b1, 8'h05, 8'h55,  1'b0, 1'b1, 8'h05,  8'h00,  1'b0, 8'd0);
    cyc("post_load",    1'b1, 8'h05, 8'h55,  1'b0, 1'b0, 8'h05,  8'h05,  1'b0, 8'd0);

    // 300 consecutive taken jumps; counter must stop at 255.
    for (int k = 0; k < 300; k++) begin
      logic [7:0] tgt;
      logic [7:0] prev;
      logic [7:0] cnt;
      tgt  = k[7:0];
      prev = (k == 0) ? 8'h05 : 8'(k - 1);
      cnt  = (k < 255) ? k[7:0] : 8'hFF;
      cyc($sformatf("sat%0d", k), 1'b1, 8'hAA, tgt, 1'b1, 1'b1, tgt, prev, (k != 0), cnt);
    end

    cyc("sat_rst",      1'b0, 8'hAA, 8'h11, 1'b1, 1'b1, 8'h11,  8'h00,  1'b0, 8'd0);
    cyc("sat_release",  1'b1, 8'hAA, 8'h11, 1'b0, 1'b0, 8'hAA,  8'h00,  1'b0, 8'd0);
    cyc("final_hold",   1'b1, 8'h42, 8'h11, 1'b0, 1'b0, 8'h42,  8'h00,  1'b0, 8'd0);

    @(posedge clk);
    @(posedge clk);
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expectations required 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
